// File: rtl/dmem.sv
// Data memory responder for the MEM stage: registered read, write-first bypass,
// post-reset clear sequencer and out-of-range address detection.
module dmem #(
  parameter int unsigned DMEM_ADDR_WIDTH = 12,
  parameter int unsigned DMEM_WORD_WIDTH = 16,
  parameter int unsigned DMEM_DEPTH      = 4096,
  parameter bit          CLEAR_ON_RESET  = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_mem_rd_addr,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_mem_wr_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] in_mem_wr_word,
  input  logic                       in_mem_write_en,
  output logic [DMEM_WORD_WIDTH-1:0] out_mem_rd_word,
  output logic                       out_ready,
  output logic                       out_addr_err
);

  localparam int unsigned IdxW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
  localparam logic [DMEM_ADDR_WIDTH:0] DepthL = (DMEM_ADDR_WIDTH + 1)'(DMEM_DEPTH);
  localparam logic [IdxW-1:0] LastPtr = IdxW'(DMEM_DEPTH - 1);

  typedef enum logic [1:0] {StClear, StReadyWait, StReady} state_e;

  state_e                     state_q, state_d;
  logic [IdxW-1:0]            clear_ptr_q, clear_ptr_d;
  logic                       ready_d, err_d;
  logic [DMEM_WORD_WIDTH-1:0] rd_word_d;

  logic [DMEM_WORD_WIDTH-1:0] mem [DMEM_DEPTH];
  logic                       mem_we;
  logic [IdxW-1:0]            mem_waddr;
  logic [DMEM_WORD_WIDTH-1:0] mem_wdata;

  logic            rd_in_range, wr_in_range;
  logic [IdxW-1:0] rd_idx, wr_idx;

  // Full-width unsigned compare so addresses above DMEM_DEPTH never alias.
  assign rd_in_range = {1'b0, in_mem_rd_addr} < DepthL;
  assign wr_in_range = {1'b0, in_mem_wr_addr} < DepthL;
  assign rd_idx      = in_mem_rd_addr[IdxW-1:0];
  assign wr_idx      = in_mem_wr_addr[IdxW-1:0];

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    ready_d     = out_ready;
    rd_word_d   = '0;
    err_d       = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = wr_idx;
    mem_wdata   = in_mem_wr_word;
    unique case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = clear_ptr_q;
        mem_wdata = '0;
        if (clear_ptr_q == LastPtr) begin
          state_d = StReady;
          ready_d = 1'b1;
        end else begin
          clear_ptr_d = clear_ptr_q + 1'b1;
        end
      end
      StReadyWait: begin
        state_d = StReady;
        ready_d = 1'b1;
      end
      StReady: begin
        mem_we = in_mem_write_en && wr_in_range;
        if (rd_in_range) begin
          rd_word_d = (mem_we && (in_mem_wr_addr == in_mem_rd_addr)) ? in_mem_wr_word
                                                                     : mem[rd_idx];
        end
        err_d = !rd_in_range || (in_mem_write_en && !wr_in_range);
      end
      default: begin
        state_d     = StClear;
        clear_ptr_d = '0;
        ready_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= CLEAR_ON_RESET ? StClear : StReadyWait;
      clear_ptr_q     <= '0;
      out_mem_rd_word <= '0;
      out_ready       <= 1'b0;
      out_addr_err    <= 1'b0;
    end else begin
      state_q         <= state_d;
      clear_ptr_q     <= clear_ptr_d;
      out_mem_rd_word <= rd_word_d;
      out_ready       <= ready_d;
      out_addr_err    <= err_d;
    end
  end

  // Array has no reset; it only changes through the clear sequencer or the write port.
  always_ff @(posedge clock) begin
    if (reset && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule
